// File: rtl/rf_mp.sv
// Multi-port GPR file: two prioritised write ports, combinational read ports with
// write-to-read bypass, and a sequential bulk-clear engine. Optional trace: RF_MP_TRACE_EN.
module rf_mp #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [DW-1:0]        wdata0,
    input  logic [31:0]          wpc0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [DW-1:0]        wdata1,
    input  logic [31:0]          wpc1,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 clr_done
);

    // state | meaning
    // IDLE  | normal operation; writes and bypass enabled
    // CLEAR | zeroing entry[clr_cnt] each cycle; writes dropped
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  clr_cnt, clr_cnt_nxt;
    logic           done_nxt;
    logic [DW-1:0]  mem [DEPTH];
    logic           wr_ok0, wr_ok1;

    assign wr_ok0   = we0 && (state == IDLE);
    assign wr_ok1   = we1 && (state == IDLE);
    assign clr_busy = (state == CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            clr_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = AW'(1);
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (we0 && waddr0 != '0) mem[waddr0] <= wdata0;
            if (we1 && waddr1 != '0) mem[waddr1] <= wdata1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (raddr[k*AW +: AW] == '0)
                rdata[k*DW +: DW] = '0;
            else if (BYPASS != 0 && wr_ok1 && waddr1 == raddr[k*AW +: AW])
                rdata[k*DW +: DW] = wdata1;
            else if (BYPASS != 0 && wr_ok0 && waddr0 == raddr[k*AW +: AW])
                rdata[k*DW +: DW] = wdata0;
            else
                rdata[k*DW +: DW] = mem[raddr[k*AW +: AW]];
        end
    end

`ifdef RF_MP_TRACE_EN
    // Port 0 printed first; overridden and address-0 writes still appear in the trace.
    always @(posedge clk) begin
        if (reset && state == IDLE) begin
            if (we0) $display("%d@%h: $%d <= %h", $time, wpc0, waddr0, wdata0);
            if (we1) $display("%d@%h: $%d <= %h", $time, wpc1, waddr1, wdata1);
        end
    end
`else
    logic trace_unused;
    assign trace_unused = &{1'b0, wpc0, wpc1};
`endif

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: vector table for read/write/bypass, hand sequences for
// bulk clear, clear-time write drop, and reset in the middle of a clear.
module tb_rf_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1, wpc0, wpc1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        clr_req, clr_busy, clr_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_mp dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wpc0(wpc0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wpc1(wpc1),
        .raddr(raddr), .rdata(rdata),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        clr_req = 0; raddr = '0;
    endtask

    task automatic check_all_zero(input string nm);
        int bad;
        bad = 0;
        for (int a = 1; a < 32; a++) begin
            raddr = {a[4:0], a[4:0]};
            #1;
            if (rdata !== 64'h0) bad++;
        end
        chk(nm, bad, 0);
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we0 = 1; waddr0 = i[4:0]; wdata0 = base + i;
        end
        @(negedge clk);
        we0 = 0;
    endtask

    initial begin
        int busy_n, done_n;

        vt[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,       5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vt[1] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[2] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h12345678, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF};
        vt[3] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       5'd0,  5'd1,  32'h0,        32'h0};
        vt[4] = '{1, 5'd7, 32'h1,        1, 5'd7, 32'h2,       5'd7,  5'd5,  32'h2,        32'hDEADBEEF};
        vt[5] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       5'd7,  5'd7,  32'h2,        32'h2};
        vt[6] = '{1, 5'd9, 32'hAAAA,     1, 5'd10, 32'hBBBB,   5'd9,  5'd10, 32'hAAAA,     32'hBBBB};
        vt[7] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       5'd9,  5'd10, 32'hAAAA,     32'hBBBB};
        vt[8] = '{1, 5'd9, 32'hCCCC,     0, 5'd0, 32'h0,       5'd9,  5'd31, 32'hCCCC,     32'h0};

        idle_inputs();
        wpc0 = 32'h0040_0000; wpc1 = 32'h0040_0004;
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, clr_busy}, 0);
        chk("rst_done", {31'b0, clr_done}, 0);
        check_all_zero("rst_regs");
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
            we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
            raddr = {vt[i].ra1, vt[i].ra0};
            #1;
            chk($sformatf("vec%0d_rd0", i), rdata[31:0], vt[i].e0);
            chk($sformatf("vec%0d_rd1", i), rdata[63:32], vt[i].e1);
        end
        @(negedge clk);
        idle_inputs();
        raddr = {5'd0, 5'd9};
        #1;
        chk("vec8_after", rdata[31:0], 32'hCCCC);

        // Bulk clear with a write into an already-cleared entry and a retrigger attempt.
        fill(0);
        raddr = {5'd31, 5'd17};
        #1;
        chk("fill_17", rdata[31:0], 32'd17);
        chk("fill_31", rdata[63:32], 32'd31);
        @(negedge clk);
        clr_req = 1;
        @(negedge clk);
        clr_req = 0;
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            clr_req = (clr_busy && busy_n == 5);
            if (clr_busy && busy_n == 10) begin
                we0 = 1; waddr0 = 5'd3; wdata0 = 32'h33; raddr = {5'd0, 5'd3};
                #1;
                chk("clr_no_bypass", rdata[31:0], 32'h0);
            end else begin
                we0 = 0;
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("clr_busy_cycles", busy_n, 31);
        chk("clr_done_pulses", done_n, 1);
        chk("clr_busy_end", {31'b0, clr_busy}, 0);
        raddr = {5'd0, 5'd3};
        #1;
        chk("clr_dropped_wr", rdata[31:0], 32'h0);
        check_all_zero("clr_all_zero");

        // Reset arriving mid-clear.
        fill(32'h100);
        @(negedge clk);
        clr_req = 1;
        @(negedge clk);
        clr_req = 0;
        repeat (10) @(negedge clk);
        chk("mid_busy_before", {31'b0, clr_busy}, 1);
        reset = 0;
        #1;
        chk("mid_busy_rst", {31'b0, clr_busy}, 0);
        chk("mid_done_rst", {31'b0, clr_done}, 0);
        @(negedge clk);
        reset = 1;
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_done) done_n++;
            if (clr_busy) busy_n++;
        end
        chk("mid_no_done", done_n, 0);
        chk("mid_no_busy", busy_n, 0);
        check_all_zero("mid_all_zero");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
